// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: address width, memory size and loader states.
package imem_pkg;

    localparam int IMEM_AW    = 12;
    localparam int IMEM_BYTES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } ld_state_e;

endpackage

// File: rtl/imem_xsum.sv
// 8-bit XOR accumulator with synchronous clear and enable; used by imem_loader
// only when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_xsum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] xsum
);

    // Running XOR of every enabled byte since the last clear.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            xsum <= 8'h00;
        end else if (en) begin
            xsum <= xsum ^ din;
        end else begin
            xsum <= xsum;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: little-endian 16-bit length header,
// then payload bytes written to BASE_ADDR upward. Optional trailing XOR
// checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [IMEM_AW-1:0] mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               core_hold
);

    localparam logic [IMEM_AW-1:0] BASE  = IMEM_AW'(BASE_ADDR);
    localparam logic [16:0]        LIMIT = 17'(MEM_BYTES - BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ld_state_e AFTER_PAYLOAD = ST_CHECK;
`else
    localparam ld_state_e AFTER_PAYLOAD = ST_DONE;
`endif

    ld_state_e   state_r;
    ld_state_e   state_s;
    logic [7:0]  len_lo_r;
    logic [15:0] len_r;
    logic [15:0] cnt_r;
    logic [15:0] len_full_s;
    logic        hs_s;
    logic        last_s;
    logic        start_ok_s;

    assign hs_s       = in_valid && in_ready;
    assign len_full_s = {in_data, len_lo_r};
    assign last_s     = (cnt_r == (len_r - 16'd1));
    assign start_ok_s = start && (state_r inside {ST_IDLE, ST_DONE, ST_ERR});

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xsum_s;

    imem_xsum u_xsum (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok_s),
        .en   (hs_s && (state_r == ST_DATA)),
        .din  (in_data),
        .xsum (xsum_s)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_s = ST_LEN_LO;
                else       state_s = state_r;
            end
            ST_LEN_LO: begin
                if (hs_s) state_s = ST_LEN_HI;
                else      state_s = state_r;
            end
            ST_LEN_HI: begin
                if (!hs_s)                         state_s = state_r;
                else if (len_full_s == 16'd0)      state_s = AFTER_PAYLOAD;
                else if ({1'b0, len_full_s} > LIMIT) state_s = ST_ERR;
                else                               state_s = ST_DATA;
            end
            ST_DATA: begin
                if (hs_s && last_s) state_s = AFTER_PAYLOAD;
                else                state_s = state_r;
            end
            ST_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (!hs_s)                  state_s = state_r;
                else if (in_data == xsum_s) state_s = ST_DONE;
                else                        state_s = ST_ERR;
`else
                state_s = ST_ERR;
`endif
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_r)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: done  = 1'b1;
            ST_ERR:  error = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
        core_hold = !(done || error);
    end

    // Header capture, payload counter and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo_r  <= 8'h00;
            len_r     <= 16'h0000;
            cnt_r     <= 16'h0000;
            mem_we    <= 1'b0;
            mem_addr  <= {IMEM_AW{1'b0}};
            mem_wdata <= 8'h00;
        end else begin
            mem_we <= 1'b0;
            case (state_r)
                ST_LEN_LO: begin
                    if (hs_s) len_lo_r <= in_data;
                    else      len_lo_r <= len_lo_r;
                end
                ST_LEN_HI: begin
                    if (hs_s) begin
                        len_r <= len_full_s;
                        cnt_r <= 16'h0000;
                    end else begin
                        len_r <= len_r;
                    end
                end
                ST_DATA: begin
                    if (hs_s) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE + cnt_r[IMEM_AW-1:0];
                        mem_wdata <= in_data;
                        cnt_r     <= cnt_r + 16'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checks writes against a
// load-level model and pins basic-load writes with literal values.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int TB_MEM  = 4096;
    localparam int TB_BASE = 0;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_hold;

    int vectors = 0;
    int fails   = 0;

    logic [11:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [11:0] obs_addr_q[$];
    logic [7:0]  obs_data_q[$];
    logic        prev_hs = 1'b0;
    logic [11:0] ea;
    logic [7:0]  ed;
    bit          exp_done;
    bit          exp_err;

    imem_loader #(.MEM_BYTES(TB_MEM), .BASE_ADDR(TB_BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .core_hold (core_hold)
    );

    always #5 clk = ~clk;

    // Every write must follow a handshake one cycle earlier and match the model.
    always @(negedge clk) begin
        if (mem_we) begin
            vectors++;
            if (!prev_hs || exp_addr_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %02h, required no write", mem_addr, mem_wdata);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (mem_addr !== ea || mem_wdata !== ed) begin
                    fails++;
                    $display("FAIL write: got (%0h,%02h), required (%0h,%02h)", mem_addr, mem_wdata, ea, ed);
                end
            end
            obs_addr_q.push_back(mem_addr);
            obs_data_q.push_back(mem_wdata);
        end
        prev_hs = in_valid && in_ready && !rst;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_error"},     32'(error),     32'd0);
        check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   got;
        int   n;
        in_valid = 1'b1;
        in_data  = b;
        got = 0;
        n   = 0;
        while (!got && n < 64) begin
            rdy = in_ready;
            tick();
            if (rdy) got = 1;
            n++;
        end
        in_valid = 1'b0;
        vectors++;
        if (!got) begin
            fails++;
            $display("FAIL send_timeout: got in_ready low for 64 cycles, required byte %02h accepted", b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Load-level model: length header decides writes and final status.
    task automatic model_load(input bq_t b);
        int         len;
        logic [7:0] x;
        len = {b[1], b[0]};
        x   = 8'h00;
        if (len > TB_MEM - TB_BASE) begin
            exp_done = 0;
            exp_err  = 1;
        end else begin
            for (int k = 0; k < len; k++) begin
                exp_addr_q.push_back(12'(TB_BASE + k));
                exp_data_q.push_back(b[2 + k]);
                x = x ^ b[2 + k];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_done = (b[2 + len] == x);
`else
            exp_done = 1;
`endif
            exp_err = !exp_done;
        end
    endtask

    task automatic run_load(input string tag, input bq_t b, input int stall_at);
        model_load(b);
        obs_addr_q.delete();
        obs_data_q.delete();
        pulse_start();
        check({tag, "_start_busy"},  32'(busy),     32'd1);
        check({tag, "_start_done"},  32'(done),     32'd0);
        check({tag, "_start_error"}, 32'(error),    32'd0);
        check({tag, "_start_ready"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < b.size(); i++) begin
            if (i == stall_at) repeat (5) tick();
            send_byte(b[i]);
        end
        tick();
        check({tag, "_pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
        check({tag, "_done"},      32'(done),      32'(exp_done));
        check({tag, "_error"},     32'(error),     32'(exp_err));
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_core_hold"}, 32'(core_hold), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    endtask

    logic [11:0] pin_a [4] = '{12'h000, 12'h001, 12'h002, 12'h003};
    logic [7:0]  pin_d [4] = '{8'h13, 8'h06, 8'h50, 8'h00};

    initial begin
        bq_t b;

        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check("idle_core_hold", 32'(core_hold), 32'd1);

        // Basic load with literal pins on the written bytes.
        b = '{8'h04, 8'h00, 8'h13, 8'h06, 8'h50, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(8'h45);
`endif
        run_load("basic", b, -1);
        check("basic_nwrites", 32'(obs_addr_q.size()), 32'd4);
        if (obs_addr_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("basic_pin_addr%0d", k), 32'(obs_addr_q[k]), 32'(pin_a[k]));
                check($sformatf("basic_pin_data%0d", k), 32'(obs_data_q[k]), 32'(pin_d[k]));
            end
        end
        check("basic_pin_done", 32'(done), 32'd1);

        // Zero length, restarted from DONE.
        b = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(8'h00);
`endif
        run_load("zero", b, -1);
        check("zero_nwrites", 32'(obs_addr_q.size()), 32'd0);

        // Oversize length.
        b = '{8'h01, 8'h10};
        run_load("oversize", b, -1);
        check("oversize_pin_error", 32'(error), 32'd1);
        check("oversize_nwrites", 32'(obs_addr_q.size()), 32'd0);

        // Stall mid-payload, restarted from ERR.
        b = '{8'h03, 8'h00, 8'hAA, 8'h55, 8'h0F};
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(8'hF0);
`endif
        run_load("stall", b, 4);
        check("stall_nwrites", 32'(obs_addr_q.size()), 32'd3);

        // Exactly MEM_BYTES is accepted into the payload phase.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h10);
        check("max_len_busy",  32'(busy),     32'd1);
        check("max_len_error", 32'(error),    32'd0);
        check("max_len_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        tick();
        tick();
        check_reset_vals("max_len_rst");
        rst = 1'b0;
        tick();

        // Reset after 2 of 4 payload bytes, then a restarted load.
        exp_addr_q.push_back(12'h000);
        exp_data_q.push_back(8'h11);
        exp_addr_q.push_back(12'h001);
        exp_data_q.push_back(8'h22);
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        tick();
        tick();
        check_reset_vals("midload_rst");
        check("midload_pending", 32'(exp_addr_q.size()), 32'd0);
        rst = 1'b0;
        tick();
        b = '{8'h02, 8'h00, 8'h77, 8'h88};
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(8'hFF);
`endif
        run_load("restart", b, -1);
        check("restart_nwrites", 32'(obs_addr_q.size()), 32'd2);
        if (obs_addr_q.size() > 0) check("restart_first_addr", 32'(obs_addr_q[0]), 32'(TB_BASE));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong trailer: payload still written, load reports error.
        b = '{8'h04, 8'h00, 8'h13, 8'h06, 8'h50, 8'h00, 8'h44};
        run_load("bad_xsum", b, -1);
        check("bad_xsum_pin_error", 32'(error), 32'd1);
        check("bad_xsum_nwrites", 32'(obs_addr_q.size()), 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
